lsu_dmem_bridge: RTL and testbench

//  Downstream of the RV32 core's load/store port. Turns the core's level-held request /

---
 rtl/lsu_bridge_pkg.sv | 9 +
 rtl/lsu_mmio_regs.sv | 42 ++++
 rtl/lsu_dmem_bridge.sv | 127 ++++++++++++
 tb/tb_lsu_dmem_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bridge_pkg.sv
// rtl/lsu_bridge_pkg.sv - shared FSM state type and MMIO register offsets for the LSU/DMEM bridge
package lsu_bridge_pkg;

  typedef enum logic [1:0] {IDLE, RWAIT, RACK, WACK} lsu_state_t;

  localparam logic [3:0] MMIO_OFF_CYCLE = 4'h0;
  localparam logic [3:0] MMIO_OFF_GPIO  = 4'h4;

endpackage

// File: rtl/lsu_mmio_regs.sv
// rtl/lsu_mmio_regs.sv - MMIO cycle counter and byte-strobed GPIO register (LSU_BRIDGE_MMIO_EN builds)
module lsu_mmio_regs
  import lsu_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_off,
  input  logic [3:0]  wr_strb,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_off,
  output logic [31:0] rd_data,
  output logic [31:0] gpio
);

  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      gpio      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_en && (wr_off == MMIO_OFF_GPIO)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) gpio[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // CYCLE is read-only: writes to it fall through the GPIO compare above and are dropped.
  always_comb begin
    rd_data = '0;
    case (rd_off)
      MMIO_OFF_CYCLE: rd_data = cycle_cnt;
      MMIO_OFF_GPIO:  rd_data = gpio;
      default:        rd_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_bridge.sv
// rtl/lsu_dmem_bridge.sv - core load/store handshake to 1-cycle-latency data BRAM; MMIO window with LSU_BRIDGE_MMIO_EN
module lsu_dmem_bridge
  import lsu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH_D = 10,
  parameter int          DATA_WIDTH_D = 32,
  parameter logic [3:0]  MMIO_NIB     = 4'h1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rready_cpu,
  output logic                    rvalid_cpu,
  input  logic                    wvalid_cpu,
  output logic                    wready_cpu,
  input  logic [3:0]              strb_cpu,
  input  logic [31:0]             addr_cpu,
  input  logic [31:0]             data_cpu_o,
  output logic [31:0]             data_cpu_i,
  output logic                    dmem_en,
  output logic [3:0]              dmem_we,
  output logic [ADDR_WIDTH_D-1:0] dmem_addr,
  output logic [DATA_WIDTH_D-1:0] dmem_wdata,
  input  logic [DATA_WIDTH_D-1:0] dmem_rdata,
  output logic [31:0]             gpio_o
);

  lsu_state_t  state, state_nxt;
  logic        accept_wr;
  logic        mmio_sel;
  logic [31:0] rd_value;
  logic        unused_ok;

  assign accept_wr  = (state == IDLE) && wvalid_cpu;
  assign dmem_addr  = addr_cpu[ADDR_WIDTH_D+1:2];
  assign dmem_wdata = data_cpu_o;

`ifdef LSU_BRIDGE_MMIO_EN
  logic [3:0]  mmio_off;
  logic [3:0]  mmio_off_q;
  logic        mmio_sel_q;
  logic        mmio_wr;
  logic [31:0] mmio_rdata;

  // Anything outside the first 16 bytes of the window is steered to an unmapped offset (reads 0).
  assign mmio_sel = (addr_cpu[31:28] == MMIO_NIB);
  assign mmio_off = (addr_cpu[27:4] == 24'd0) ? {addr_cpu[3:2], 2'b00} : 4'hC;
  assign mmio_wr  = !rst && accept_wr && mmio_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_sel_q <= 1'b0;
      mmio_off_q <= '0;
    end else if (state == IDLE) begin
      mmio_sel_q <= mmio_sel;
      mmio_off_q <= mmio_off;
    end
  end

  lsu_mmio_regs u_mmio_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mmio_wr),
    .wr_off  (mmio_off),
    .wr_strb (strb_cpu),
    .wr_data (data_cpu_o),
    .rd_off  (mmio_off_q),
    .rd_data (mmio_rdata),
    .gpio    (gpio_o)
  );

  assign rd_value  = mmio_sel_q ? mmio_rdata : dmem_rdata;
  assign unused_ok = &{1'b0, addr_cpu[1:0]};
`else
  assign mmio_sel  = 1'b0;
  assign rd_value  = dmem_rdata;
  assign gpio_o    = '0;
  assign unused_ok = &{1'b0, addr_cpu[31:ADDR_WIDTH_D+2], addr_cpu[1:0], MMIO_NIB};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_cpu_i <= '0;
    end else begin
      state <= state_nxt;
      if (state == RWAIT) data_cpu_i <= rd_value;
    end
  end

  // Writes take priority; a read held alongside is picked up on the next return to IDLE.
  always_comb begin
    state_nxt  = state;
    dmem_en    = 1'b0;
    dmem_we    = 4'h0;
    rvalid_cpu = 1'b0;
    wready_cpu = 1'b0;
    case (state)
      IDLE: begin
        if (wvalid_cpu) begin
          state_nxt = WACK;
          dmem_en   = !mmio_sel;
          dmem_we   = mmio_sel ? 4'h0 : strb_cpu;
        end else if (rready_cpu) begin
          state_nxt = RWAIT;
          dmem_en   = !mmio_sel;
        end
      end
      RWAIT: state_nxt = RACK;
      RACK: begin
        state_nxt  = IDLE;
        rvalid_cpu = 1'b1;
      end
      WACK: begin
        state_nxt  = IDLE;
        wready_cpu = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      dmem_en    = 1'b0;
      dmem_we    = 4'h0;
      rvalid_cpu = 1'b0;
      wready_cpu = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// tb/tb_lsu_dmem_bridge.sv - self-checking bench for lsu_dmem_bridge (MMIO cases under LSU_BRIDGE_MMIO_EN)
module tb_lsu_dmem_bridge;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rready_cpu, rvalid_cpu, wvalid_cpu, wready_cpu;
  logic [3:0]    strb_cpu;
  logic [31:0]   addr_cpu, data_cpu_o, data_cpu_i;
  logic          dmem_en;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic [31:0]   gpio_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int tb_cyc    = 0;

  logic [31:0] bram [0:(1<<AW)-1];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  lsu_dmem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .rready_cpu (rready_cpu),
    .rvalid_cpu (rvalid_cpu),
    .wvalid_cpu (wvalid_cpu),
    .wready_cpu (wready_cpu),
    .strb_cpu   (strb_cpu),
    .addr_cpu   (addr_cpu),
    .data_cpu_o (data_cpu_o),
    .data_cpu_i (data_cpu_i),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .gpio_o     (gpio_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Synchronous BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_rdata <= bram[dmem_addr];
      for (int b = 0; b < 4; b++)
        if (dmem_we[b]) bram[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    int k;
    k = int'(a[AW+1:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void ref_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[AW+1:2])] = w;
  endfunction

  task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit to_bram,
                       output logic [31:0] rd, output int lat);
    logic [31:0] exp_rd;
    logic [3:0]  exp_we;
    exp_rd = ref_read(a);
    exp_we = (wr && to_bram) ? s : 4'h0;
    @(posedge clk); #1;
    addr_cpu   = a;
    data_cpu_o = d;
    strb_cpu   = s;
    wvalid_cpu = wr;
    rready_cpu = !wr;
    @(negedge clk);
    check("accept_en", {31'b0, dmem_en}, {31'b0, to_bram});
    check("accept_we", {28'b0, dmem_we}, {28'b0, exp_we});
    if (to_bram) check("accept_addr", 32'(dmem_addr), 32'(a[AW+1:2]));
    if (wr && to_bram) ref_write(a, d, s);
    lat = -1;
    rd  = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wr ? wready_cpu : rvalid_cpu) begin
        lat = k;
        rd  = data_cpu_i;
        break;
      end
    end
    check(wr ? "wr_latency" : "rd_latency", 32'(lat), wr ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    wvalid_cpu = 1'b0;
    rready_cpu = 1'b0;
    @(negedge clk);
    check("ack_one_pulse", {30'b0, rvalid_cpu, wready_cpu}, 32'h0);
    if (wr) check("rd_data_hold", data_cpu_i, last_rd);
    else begin
      if (to_bram) check("rd_data_ref", rd, exp_rd);
      last_rd = rd;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, d;
    logic [3:0]  s;
    bit          wr;
    int          lat, wcnt, rcnt, wcyc, rcyc, seen;
    bit          drop_w, drop_r;

    for (int i = 0; i < (1 << AW); i++) bram[i] = 32'h0;
    last_rd = 32'h0;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h0000_0010, 32'h00AB0000, 4'h4, 32'h0};
    tbl[3] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEABBEEF};
    tbl[4] = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0};
    tbl[5] = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h0};
    tbl[6] = '{1'b0, 32'h0000_0023, 32'h0,        4'h0, 32'h11223344};
    tbl[7] = '{1'b0, 32'h0000_0013, 32'h0,        4'h0, 32'hDEABBEEF};

    // Reset with both requests held: nothing may reach the BRAM or the core.
    rst        = 1'b1;
    rready_cpu = 1'b1;
    wvalid_cpu = 1'b1;
    strb_cpu   = 4'hF;
    addr_cpu   = 32'h10;
    data_cpu_o = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_en", {31'b0, dmem_en}, 32'h0);
    check("rst_dmem_we", {28'b0, dmem_we}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid_cpu}, 32'h0);
    check("rst_wready", {31'b0, wready_cpu}, 32'h0);
    check("rst_data_cpu_i", data_cpu_i, 32'h0);
    check("rst_gpio", gpio_o, 32'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    rready_cpu = 1'b0;
    wvalid_cpu = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, 1'b1, rd, lat);
      if (!tbl[i].wr) check($sformatf("table_rd_%0d", i), rd, tbl[i].exp);
    end

    // Simultaneous read and write: write acks first, read follows after IDLE is re-entered.
    @(posedge clk); #1;
    addr_cpu   = 32'h40;
    data_cpu_o = 32'hCAFEF00D;
    strb_cpu   = 4'hF;
    wvalid_cpu = 1'b1;
    rready_cpu = 1'b1;
    ref_write(32'h40, 32'hCAFEF00D, 4'hF);
    wcnt = 0; rcnt = 0; wcyc = -1; rcyc = -1;
    drop_w = 1'b0; drop_r = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (drop_w) wvalid_cpu = 1'b0;
      if (drop_r) rready_cpu = 1'b0;
      @(negedge clk);
      if (wready_cpu) begin wcnt++; wcyc = c; drop_w = 1'b1; end
      if (rvalid_cpu) begin rcnt++; rcyc = c; drop_r = 1'b1; rd = data_cpu_i; end
    end
    check("simul_wr_cycle", 32'(wcyc), 32'd1);
    check("simul_rd_cycle", 32'(rcyc), 32'd4);
    check("simul_wr_pulses", 32'(wcnt), 32'd1);
    check("simul_rd_pulses", 32'(rcnt), 32'd1);
    check("simul_rd_data", rd, 32'hCAFEF00D);
    last_rd = rd;

    // Reset while waiting for read data: no ack, data register cleared.
    @(posedge clk); #1;
    addr_cpu   = 32'h10;
    rready_cpu = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rwait_en", {31'b0, dmem_en}, 32'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    rready_cpu = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid_cpu) seen++;
    end
    check("rst_rwait_no_ack", 32'(seen), 32'h0);
    check("rst_rwait_data", data_cpu_i, 32'h0);
    last_rd = 32'h0;
    do_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, lat);
    check("after_rst_read", rd, 32'hDEABBEEF);

`ifndef LSU_BRIDGE_MMIO_EN
    do_op(1'b1, 32'h1000_0010, 32'h600DF00D, 4'hF, 1'b1, rd, lat);
    do_op(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, rd, lat);
    check("alias_read", rd, 32'h600DF00D);
    check("gpio_tied_low", gpio_o, 32'h0);
`else
    begin : mmio_tests
      logic [31:0] c1, c2;
      int          t1, t2;
      do_op(1'b0, 32'h1000_0000, 32'h0, 4'h0, 1'b0, c1, lat);
      t1 = tb_cyc;
      repeat (7) @(posedge clk);
      do_op(1'b0, 32'h1000_0000, 32'h0, 4'h0, 1'b0, c2, lat);
      t2 = tb_cyc;
      check("cycle_delta", c2 - c1, 32'(t2 - t1));
      do_op(1'b1, 32'h1000_0004, 32'hFFFFFF5A, 4'b0001, 1'b0, rd, lat);
      check("gpio_out", gpio_o, 32'h0000005A);
      do_op(1'b0, 32'h1000_0004, 32'h0, 4'h0, 1'b0, rd, lat);
      check("gpio_read", rd, 32'h0000005A);
      do_op(1'b0, 32'h1000_0008, 32'h0, 4'h0, 1'b0, rd, lat);
      check("mmio_unmapped", rd, 32'h0);
    end
`endif

    // Random traffic over 16 words with random upper address bits.
    for (int i = 0; i < 80; i++) begin
      a = $urandom & 32'hFFFF_F03F;
`ifdef LSU_BRIDGE_MMIO_EN
      a[31:28] = 4'h0;
`endif
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      do_op(wr, a, d, s, 1'b1, rd, lat);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
